fetch_decode_queue: RTL
=======================

# fetch_decode_queue

Instruction queue between the instruction fetch stage and decode. It captures each new (instruction, PC) pair that fetch presents while `if_ready` is high, and buffers up to `DEPTH` entries. It presents them to decode in order with a valid/ready handshake, and drives the `id_ready`/`id_stall` back-pressure that fetch samples. A flush input from branch resolution discards all buffered entries.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `INST_WIDTH`, 32, instruction width
- `PC_WIDTH`, 64, PC width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `if_ready`  in  1  fetch is presenting a valid `if_inst`/`if_pc`
- `if_inst`  in  32  instruction from fetch
- `if_pc`  in  64  PC of `if_inst` (fetch's `IF_PCplus4_out`)
- `flush`  in  1  discard all entries and the duplicate-tracking state
- `dq_ready`  in  1  decode accepts the head entry this cycle
- `dq_valid`  out  1  head entry valid
- `dq_inst`  out  32  head instruction; 32'h01000000 when empty
- `dq_pc`  out  64  head PC; 0 when empty
- `id_ready`  out  1  to fetch: at least 2 free slots
- `id_stall`  out  1  to fetch: queue full
- `overflow_err`  out  1  sticky; an enqueue was dropped because the queue was full

## Operation
- Storage: circular buffer of `DEPTH` entries, each {inst, pc}.
  - Read pointer `rp` and write pointer `wp` are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - `count` is log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- Duplicate suppression: fetch holds `if_ready` high for several cycles with the same outputs.
  - Registers `last_pc` and `last_vld` track the most recent capture.
  - Enqueue candidate `enq_req` = `if_ready` && !`flush` && (!`last_vld` || `if_pc` != `last_pc`).
  - On every accepted enqueue: `last_pc` ← `if_pc`, `last_vld` ← 1.
  - A fetch bubble (`if_ready`=0) does not clear `last_vld`.
- Dequeue: `deq` = `dq_valid` && `dq_ready` && !`flush`. On `deq`, `rp` advances.
- Enqueue accept rule: `enq` = `enq_req` && (`count` < `DEPTH` || `deq`).
  - When full with a simultaneous dequeue, the enqueue is accepted and `count` is unchanged.
  - `enq_req` while full with no dequeue: entry dropped, `overflow_err` ← 1.
- Count update: `count` += `enq` − `deq`.
- Flush, highest priority:
  - `rp`, `wp` and `count` ← 0; `last_vld` ← 0.
  - Enqueue and dequeue in the same cycle are suppressed.
  - `overflow_err` is not cleared.
- Outputs:
  - `dq_valid` = (`count` != 0).
  - `dq_inst`/`dq_pc` = entry at `rp` when valid, else 32'h01000000 / 0.
  - `id_ready` = (`DEPTH` − `count` ≥ 2).
  - `id_stall` = (`count` == `DEPTH`).
- Reset state: `count`=0, `rp`=`wp`=0, `last_vld`=0, `last_pc`=0, `overflow_err`=0.
  - Resulting outputs: `dq_valid`=0, `dq_inst`=32'h01000000, `dq_pc`=0, `id_ready`=1, `id_stall`=0.
  - Reset mid-operation discards all entries.
- Storage array is not reset; entry contents are unobservable while the queue is empty.

## Timing
- Enqueue latency: an entry captured at edge N is visible on `dq_*` after edge N; no same-cycle bypass from `if_*` to `dq_*`.
- Dequeue: head advances at the edge where `deq`=1; the next entry appears combinationally after that edge.
- Full throughput: one enqueue and one dequeue per cycle, sustained.
- `id_ready`, `id_stall` and `dq_valid` are functions of registered `count` only; they have no combinational path from `if_*` or `dq_ready`.
- Back-pressure margin: `id_ready` drops at `count` ≥ `DEPTH`−1. This leaves one slot for the instruction fetch delivers after sampling `id_ready`=1.

## Test plan
- Reset, then hold `if_ready`=1, `if_pc`=0x40, `if_inst`=0x9DE3BFA0 for 5 cycles, `dq_ready`=0 -> exactly one entry, `count`=1, `dq_pc`=0x40, `id_ready`=1.
- Enqueue PCs 0x40, 0x44, 0x48, 0x4C with `dq_ready`=0 -> `id_ready`=0 after the 3rd, `id_stall`=1 after the 4th; a 5th PC 0x50 sets `overflow_err`=1 and `count` stays 4.
- Full queue, `dq_ready`=1 and new PC 0x50 in the same cycle -> head 0x40 popped, 0x50 enqueued, `count`=4; draining yields 0x44, 0x48, 0x4C, 0x50 in order.
- Stream 12 distinct PCs with `dq_ready`=1 every cycle -> output order matches input order across pointer wrap; `count` ≤ 1; no overflow.
- Three entries queued, assert `flush` with `if_ready`=1 and a new PC -> next cycle `count`=0, `dq_valid`=0, `dq_inst`=0x01000000; the same PC re-presented afterwards is enqueued (`last_vld` cleared).
- Assert `reset` with 2 entries queued and `overflow_err`=1 -> all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus: capture side from fetch, head side toward decode,
// and the back-pressure and error flags that go back to fetch.
interface fetch_decode_queue_if #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 64
);
  logic                  if_ready;
  logic [INST_WIDTH-1:0] if_inst;
  logic [PC_WIDTH-1:0]   if_pc;
  logic                  flush;
  logic                  dq_ready;
  logic                  dq_valid;
  logic [INST_WIDTH-1:0] dq_inst;
  logic [PC_WIDTH-1:0]   dq_pc;
  logic                  id_ready;
  logic                  id_stall;
  logic                  overflow_err;

  modport master (
    output if_ready, if_inst, if_pc, flush, dq_ready,
    input  dq_valid, dq_inst, dq_pc, id_ready, id_stall, overflow_err
  );

  modport slave (
    input  if_ready, if_inst, if_pc, flush, dq_ready,
    output dq_valid, dq_inst, dq_pc, id_ready, id_stall, overflow_err
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode, with suppression of
// repeated captures while fetch holds the same PC, and a sticky overflow flag.
module fetch_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);
  localparam logic [INST_WIDTH-1:0] EMPTY_INST = INST_WIDTH'(32'h0100_0000);

  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];

  logic [AW-1:0]       rp;
  logic [AW-1:0]       wp;
  logic [CW-1:0]       count;
  logic [PC_WIDTH-1:0] last_pc;
  logic                last_vld;
  logic                overflow_err;

  logic enq_req;
  logic deq;
  logic enq;
  logic full;

  assign full    = (count == FULL_COUNT);
  assign enq_req = bus.if_ready && !bus.flush && (!last_vld || bus.if_pc != last_pc);
  assign deq     = (count != '0) && bus.dq_ready && !bus.flush;
  assign enq     = enq_req && (!full || deq);

  // Pointer, occupancy and duplicate-tracking state; flush wins over everything
  // except reset, and deliberately leaves the sticky overflow flag alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp           <= '0;
      wp           <= '0;
      count        <= '0;
      last_pc      <= '0;
      last_vld     <= 1'b0;
      overflow_err <= 1'b0;
    end else if (bus.flush) begin
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
      last_vld <= 1'b0;
    end else begin
      if (enq) begin
        wp       <= wp + 1'b1;
        last_pc  <= bus.if_pc;
        last_vld <= 1'b1;
      end
      if (deq) begin
        rp <= rp + 1'b1;
      end
      count <= count + CW'(enq) - CW'(deq);
      if (enq_req && !enq) begin
        overflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      mem_inst[wp] <= bus.if_inst;
      mem_pc[wp]   <= bus.if_pc;
    end
  end

  // Back-pressure keeps one slot spare for the fetch already in flight.
  always_comb begin
    bus.dq_valid     = (count != '0);
    bus.dq_inst      = EMPTY_INST;
    bus.dq_pc        = '0;
    if (count != '0) begin
      bus.dq_inst = mem_inst[rp];
      bus.dq_pc   = mem_pc[rp];
    end
    bus.id_ready     = (count <= READY_LIMIT);
    bus.id_stall     = full;
    bus.overflow_err = overflow_err;
  end
endmodule
